// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared types for the bit-serial adder sequencer.
//               sa_state_t - controller state encoding (IDLE / RUN / DONE).
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } sa_state_t;

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/fa.sv
`default_nettype none
// ============================================================================
// Module      : fa
// Description : Single-bit full-adder cell.
//   A, B, Cin : in  1  addend bits and carry-in
//   Y         : out 1  sum bit
//   Cout      : out 1  carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module fa (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Y,
    output logic Cout
);

    logic w_p;

    assign w_p  = A ^ B;
    assign Y    = w_p ^ Cin;
    assign Cout = (A & B) | (Cin & w_p);

endmodule : fa
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial WIDTH-bit adder. One full-adder cell is reused for
//               every bit position, LSB first, one bit per clock, with a
//               registered carry. Valid/ready handshake on input and output,
//               one operation in flight.
//   clk, rst            : in   clock (rising edge), synchronous active-high reset
//   in_valid / in_ready : in/out  operand handshake (ready only in IDLE)
//   A, B, Cin           : in   operands, sampled on accept only
//   out_valid/out_ready : out/in  result handshake (valid only in DONE)
//   Y, Cout             : out  (A+B+Cin) mod 2^WIDTH and bit WIDTH of the sum
//   busy                : out  high while an operation is in RUN or DONE
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Cout,
    output logic             busy
);

    localparam int              CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);

    sa_state_t        r_state_q, w_state_d;
    logic [WIDTH-1:0] r_a_sh_q,  w_a_sh_d;
    logic [WIDTH-1:0] r_b_sh_q,  w_b_sh_d;
    logic [WIDTH-1:0] r_y_q,     w_y_d;
    logic             r_carry_q, w_carry_d;
    logic             r_cout_q,  w_cout_d;
    logic [CNT_W-1:0] r_cnt_q,   w_cnt_d;

    logic             w_fa_y;
    logic             w_fa_cout;

    // The shared adder always looks at the current LSB of each shift register.
    fa u_fa (
        .A    (r_a_sh_q[0]),
        .B    (r_b_sh_q[0]),
        .Cin  (r_carry_q),
        .Y    (w_fa_y),
        .Cout (w_fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_a_sh_q  <= '0;
            r_b_sh_q  <= '0;
            r_y_q     <= '0;
            r_carry_q <= 1'b0;
            r_cout_q  <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_a_sh_q  <= w_a_sh_d;
            r_b_sh_q  <= w_b_sh_d;
            r_y_q     <= w_y_d;
            r_carry_q <= w_carry_d;
            r_cout_q  <= w_cout_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_a_sh_d  = r_a_sh_q;
        w_b_sh_d  = r_b_sh_q;
        w_y_d     = r_y_q;
        w_carry_d = r_carry_q;
        w_cout_d  = r_cout_q;
        w_cnt_d   = r_cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        unique case (r_state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_a_sh_d  = A;
                    w_b_sh_d  = B;
                    w_carry_d = Cin;
                    w_cnt_d   = '0;
                    w_state_d = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                w_a_sh_d  = r_a_sh_q >> 1;
                w_b_sh_d  = r_b_sh_q >> 1;
                // Sum bits enter at the MSB so that after WIDTH shifts the
                // first (LSB) sum bit has arrived at position 0. Written as a
                // shift plus bit overwrite so WIDTH=1 needs no special case.
                w_y_d            = r_y_q >> 1;
                w_y_d[WIDTH-1]   = w_fa_y;
                w_carry_d = w_fa_cout;
                w_cnt_d   = r_cnt_q + CNT_W'(1);
                if (r_cnt_q == c_LAST_CNT) begin
                    w_cout_d  = w_fa_cout;
                    w_state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    assign Y    = r_y_q;
    assign Cout = r_cout_q;

endmodule : serial_add_ctrl
`default_nettype wire
